// File: rtl/skein_block_loader.sv
// Packs one or two 64-bit message words per beat into a 16-word Skein-1024 block,
// steering the external word_counter, zero-padding short final blocks and handing blocks downstream.
module skein_block_loader #(
   parameter int unsigned NUM_WORDS = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [127:0]              in_data_i,
   input  logic                      in_double_i,
   input  logic                      in_last_i,
   input  logic [3:0]                word_counter_o,
   output logic                      word_counter_reset_o,
   output logic                      word_counter_plus_1_o,
   output logic                      word_counter_plus_2_o,
   output logic                      block_valid_o,
   input  logic                      block_ready_i,
   output logic [NUM_WORDS*64-1:0]   block_o,
   output logic [4:0]                block_words_o,
   output logic                      block_last_o,
   output logic                      err_o
);

   typedef enum logic [1:0] {INIT, LOAD, PAD, FULL} state_t;

   state_t                   state_q, state_d;
   logic [NUM_WORDS*64-1:0]  block_q;
   logic [4:0]               words_q;
   logic                     last_q;
   logic                     err_q;

   logic                     ctl_reset, ctl_plus_1, ctl_plus_2;
   logic                     wr_lo, wr_hi, clear_buf;
   logic [63:0]              lo_data, hi_data;
   logic [4:0]               add_words;
   logic                     set_last, last_val, set_err;
   logic [3:0]               wc, wc_next;

   assign wc      = word_counter_o;
   assign wc_next = wc + 4'd1;

   always_comb begin
      state_d    = state_q;
      in_ready_o = 1'b0;
      block_valid_o = 1'b0;
      ctl_reset  = 1'b0;
      ctl_plus_1 = 1'b0;
      ctl_plus_2 = 1'b0;
      wr_lo      = 1'b0;
      wr_hi      = 1'b0;
      lo_data    = '0;
      hi_data    = '0;
      clear_buf  = 1'b0;
      add_words  = '0;
      set_last   = 1'b0;
      last_val   = 1'b0;
      set_err    = 1'b0;
      case (state_q)
         INIT: begin
            ctl_reset = 1'b1;
            clear_buf = 1'b1;
            state_d   = LOAD;
         end
         LOAD: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               wr_lo   = 1'b1;
               lo_data = in_data_i[63:0];
               // a double beat at the last slot keeps only its low word and flags an error
               if (in_double_i && (wc != 4'd15)) begin
                  wr_hi      = 1'b1;
                  hi_data    = in_data_i[127:64];
                  ctl_plus_2 = 1'b1;
                  add_words  = 5'd2;
               end else begin
                  ctl_plus_1 = 1'b1;
                  add_words  = 5'd1;
                  set_err    = in_double_i;
               end
               if ((ctl_plus_2 && (wc == 4'd14)) || (ctl_plus_1 && (wc == 4'd15))) begin
                  state_d  = FULL;
                  set_last = 1'b1;
                  last_val = in_last_i;
               end else if (in_last_i) begin
                  state_d  = PAD;
                  set_last = 1'b1;
                  last_val = 1'b1;
               end
            end
         end
         PAD: begin
            wr_lo = 1'b1;
            if (wc != 4'd15) begin
               wr_hi      = 1'b1;
               ctl_plus_2 = 1'b1;
               if (wc == 4'd14) begin
                  state_d = FULL;
               end
            end else begin
               ctl_plus_1 = 1'b1;
               state_d    = FULL;
            end
         end
         FULL: begin
            block_valid_o = 1'b1;
            if (block_ready_i) begin
               state_d = INIT;
            end
         end
         default: state_d = INIT;
      endcase
   end

   // INIT is the reset state, so the counter clear is held off until reset releases
   assign word_counter_reset_o  = ctl_reset & ~rst_i;
   assign word_counter_plus_1_o = ctl_plus_1;
   assign word_counter_plus_2_o = ctl_plus_2;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= INIT;
         block_q <= '0;
         words_q <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (clear_buf) begin
            block_q <= '0;
            words_q <= '0;
         end else begin
            if (wr_lo) begin
               block_q[{wc, 6'd0} +: 64] <= lo_data;
            end
            if (wr_hi) begin
               block_q[{wc_next, 6'd0} +: 64] <= hi_data;
            end
            words_q <= words_q + add_words;
         end
         if (set_last) begin
            last_q <= last_val;
         end
         if (set_err) begin
            err_q <= 1'b1;
         end
      end
   end

   assign block_o       = block_q;
   assign block_words_o = words_q;
   assign block_last_o  = last_q;
   assign err_o         = err_q;

endmodule
